// File: rtl/fabric_config_pkg.sv
// Shared constants and types for the fabric configuration loader.
// The sync word is only consulted when FABRIC_CONFIG_SYNC_EN is defined.
package fabric_config_pkg;

  localparam int unsigned WordW = 32;
  localparam logic [WordW-1:0] SYNC_WORD = 32'hFAB0_FAB1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fabric_config.sv
// Bitstream loader: streams 32-bit words into per-row frame data and pulses one frame strobe per frame.
// Optional FABRIC_CONFIG_SYNC_EN: require SYNC_WORD before loading and allow restart from DONE.
module fabric_config
  import fabric_config_pkg::*;
#(
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned NumColumns      = 6,
  parameter int unsigned NumRows         = 10
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [WordW-1:0]                      bitstream_data_i,
  input  logic                                  bitstream_valid_i,
  output logic                                  busy_o,
  output logic                                  configured_o,
  output logic [FrameBitsPerRow*NumRows-1:0]    FrameData_o,
  output logic [MaxFramesPerCol*NumColumns-1:0] FrameStrobe_o
);

  localparam int unsigned RowW    = cnt_w(NumRows);
  localparam int unsigned FrmW    = cnt_w(MaxFramesPerCol);
  localparam int unsigned ColW    = cnt_w(NumColumns);
  localparam int unsigned DataW   = FrameBitsPerRow * NumRows;
  localparam int unsigned StbW    = MaxFramesPerCol * NumColumns;
  localparam int unsigned StbIdxW = cnt_w(StbW);

  localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);
  localparam logic [FrmW-1:0] LastFrm = FrmW'(MaxFramesPerCol - 1);
  localparam logic [ColW-1:0] LastCol = ColW'(NumColumns - 1);

  if (FrameBitsPerRow != WordW) begin : g_width_check
    $error("fabric_config: FrameBitsPerRow must be 32");
  end

  state_e            state_q, state_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [FrmW-1:0]   frame_q, frame_d;
  logic [ColW-1:0]   col_q, col_d;
  logic              busy_q, busy_d;
  logic              configured_q, configured_d;
  logic [DataW-1:0]  data_q, data_d;
  logic [StbW-1:0]   strobe_q, strobe_d;
  logic              take_word_c;
  logic [StbIdxW-1:0] strobe_idx_c;

  assign strobe_idx_c = StbIdxW'(col_q) * StbIdxW'(MaxFramesPerCol) + StbIdxW'(frame_q);

  // Next-state: sync handling per state, then the shared data-word path.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    frame_d      = frame_q;
    col_d        = col_q;
    busy_d       = busy_q;
    configured_d = configured_q;
    data_d       = data_q;
    strobe_d     = '0;
    take_word_c  = 1'b0;

    if (bitstream_valid_i) begin
      case (state_q)
        ST_IDLE: begin
`ifdef FABRIC_CONFIG_SYNC_EN
          if (bitstream_data_i == SYNC_WORD) begin
            state_d = ST_LOAD;
            row_d   = '0;
            frame_d = '0;
            col_d   = '0;
            busy_d  = 1'b1;
          end
`else
          // Counters are already zero here: IDLE is only reachable through reset.
          state_d     = ST_LOAD;
          busy_d      = 1'b1;
          take_word_c = 1'b1;
`endif
        end
        ST_LOAD: take_word_c = 1'b1;
        ST_DONE: begin
`ifdef FABRIC_CONFIG_SYNC_EN
          if (bitstream_data_i == SYNC_WORD) begin
            state_d      = ST_LOAD;
            row_d        = '0;
            frame_d      = '0;
            col_d        = '0;
            busy_d       = 1'b1;
            configured_d = 1'b0;
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (take_word_c) begin
      for (int unsigned r = 0; r < NumRows; r++) begin
        if (row_q == RowW'(r)) data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = bitstream_data_i;
      end
      if (row_q == LastRow) begin
        row_d    = '0;
        strobe_d = StbW'(1) << strobe_idx_c;
        if (frame_q == LastFrm) begin
          frame_d = '0;
          if (col_q == LastCol) begin
            col_d        = '0;
            state_d      = ST_DONE;
            busy_d       = 1'b0;
            configured_d = 1'b1;
          end else begin
            col_d = col_q + ColW'(1);
          end
        end else begin
          frame_d = frame_q + FrmW'(1);
        end
      end else begin
        row_d = row_q + RowW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      frame_q      <= '0;
      col_q        <= '0;
      busy_q       <= 1'b0;
      configured_q <= 1'b0;
      data_q       <= '0;
      strobe_q     <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      frame_q      <= frame_d;
      col_q        <= col_d;
      busy_q       <= busy_d;
      configured_q <= configured_d;
      data_q       <= data_d;
      strobe_q     <= strobe_d;
    end
  end

  assign busy_o        = busy_q;
  assign configured_o  = configured_q;
  assign FrameData_o   = data_q;
  assign FrameStrobe_o = strobe_q;

endmodule

// File: tb/tb_fabric_config.sv
// Directed bench for fabric_config: expectations are queued as each word is driven and checked a cycle later.
// Adapts to the FABRIC_CONFIG_SYNC_EN build option.
module tb_fabric_config;
  import fabric_config_pkg::*;

  localparam int unsigned NR     = 10;
  localparam int unsigned NF     = 20;
  localparam int unsigned NC     = 6;
  localparam int unsigned FW     = 32;
  localparam int unsigned DW     = FW * NR;
  localparam int unsigned SW     = NF * NC;
  localparam int unsigned FRAMES = NF * NC;
  localparam int unsigned WORDS  = NR * FRAMES;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [31:0]   bitstream_data_i = '0;
  logic          bitstream_valid_i = 1'b0;
  logic          busy_o;
  logic          configured_o;
  logic [DW-1:0] FrameData_o;
  logic [SW-1:0] FrameStrobe_o;

  fabric_config #(
    .FrameBitsPerRow (FW),
    .MaxFramesPerCol (NF),
    .NumColumns      (NC),
    .NumRows         (NR)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .bitstream_data_i  (bitstream_data_i),
    .bitstream_valid_i (bitstream_valid_i),
    .busy_o            (busy_o),
    .configured_o      (configured_o),
    .FrameData_o       (FrameData_o),
    .FrameStrobe_o     (FrameStrobe_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          busy;
    logic          cfg;
    logic [SW-1:0] stb;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int errors = 0;
  int checks = 0;
  int strobes_seen = 0;

  // Reference model: position in the stream decides row and frame by arithmetic.
  int            m_state = 0;   // 0 idle, 1 load, 2 done
  int            m_n = 0;       // data words accepted in the current configuration
  logic          m_busy = 1'b0;
  logic          m_cfg = 1'b0;
  logic [DW-1:0] m_data = '0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_n     = 0;
    m_busy  = 1'b0;
    m_cfg   = 1'b0;
    m_data  = '0;
    sb_q.delete();
  endtask

  task automatic model_data(input logic [31:0] d, inout logic [SW-1:0] stb);
    int row;
    row = m_n % NR;
    m_data[row*FW +: FW] = d;
    if (row == NR - 1) stb[m_n / NR] = 1'b1;
    m_n++;
    if (m_n == WORDS) begin
      m_state = 2;
      m_busy  = 1'b0;
      m_cfg   = 1'b1;
    end
  endtask

  task automatic model_accept(input logic [31:0] d, inout logic [SW-1:0] stb);
    case (m_state)
      0: begin
`ifdef FABRIC_CONFIG_SYNC_EN
        if (d == SYNC_WORD) begin
          m_state = 1;
          m_n     = 0;
          m_busy  = 1'b1;
        end
`else
        m_state = 1;
        m_busy  = 1'b1;
        model_data(d, stb);
`endif
      end
      1: model_data(d, stb);
      default: begin
`ifdef FABRIC_CONFIG_SYNC_EN
        if (d == SYNC_WORD) begin
          m_state = 1;
          m_n     = 0;
          m_busy  = 1'b1;
          m_cfg   = 1'b0;
        end
`endif
      end
    endcase
  endtask

  // Drive one cycle from a falling edge; compare the registered result at the next falling edge.
  task automatic cyc(input logic v, input logic [31:0] d);
    exp_t e;
    logic [SW-1:0] stb;
    bitstream_valid_i = v;
    bitstream_data_i  = d;
    stb = '0;
    if (v) model_accept(d, stb);
    e.busy = m_busy;
    e.cfg  = m_cfg;
    e.stb  = stb;
    e.data = m_data;
    sb_q.push_back(e);
    @(negedge clk_i);
    e = sb_q.pop_front();
    check("busy",   DW'(busy_o),        DW'(e.busy));
    check("cfg",    DW'(configured_o),  DW'(e.cfg));
    check("strobe", DW'(FrameStrobe_o), DW'(e.stb));
    check("data",   FrameData_o,        e.data);
    if (FrameStrobe_o != '0) strobes_seen++;
  endtask

  task automatic send_sync();
`ifdef FABRIC_CONFIG_SYNC_EN
    cyc(1'b1, SYNC_WORD);
`endif
  endtask

  // Reset raised between clock edges; outputs must clear before any edge arrives.
  task automatic do_reset(input string tag);
    bitstream_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    check({tag, "_busy"},   DW'(busy_o),        '0);
    check({tag, "_cfg"},    DW'(configured_o),  '0);
    check({tag, "_strobe"}, DW'(FrameStrobe_o), '0);
    check({tag, "_data"},   FrameData_o,        '0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] w;

    #1 rst_i = 1'b1;
    #1;
    check("por_busy",   DW'(busy_o),        '0);
    check("por_cfg",    DW'(configured_o),  '0);
    check("por_strobe", DW'(FrameStrobe_o), '0);
    check("por_data",   FrameData_o,        '0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();

    // Non-sync word in IDLE, an unqualified sync, then a real sync.
    cyc(1'b1, 32'h1234_5678);
    cyc(1'b0, SYNC_WORD);
    cyc(1'b1, SYNC_WORD);
    cyc(1'b0, 32'h0);

    // One frame of back-to-back words 0..9.
    do_reset("rst1");
    send_sync();
    for (int r = 0; r < NR; r++) cyc(1'b1, 32'(r));
    cyc(1'b0, 32'h0);
    cyc(1'b0, 32'h0);

    // Full stream with valid toggling; a sync value inside LOAD is plain data.
    do_reset("rst2");
    send_sync();
    strobes_seen = 0;
    for (int i = 0; i < WORDS; i++) begin
      w = (i == 3) ? SYNC_WORD : $urandom;
      cyc(1'b1, w);
      cyc(1'b0, SYNC_WORD);
    end
    check("strobe_count", DW'(strobes_seen), DW'(FRAMES));

    // Words after completion: junk is ignored, sync restarts when enabled.
    cyc(1'b1, 32'hDEAD_BEEF);
    cyc(1'b1, SYNC_WORD);
    for (int r = 0; r < NR; r++) cyc(1'b1, 32'hA000_0000 | 32'(r));
    cyc(1'b0, 32'h0);

    // Abandon a partial load by reset, then configure from scratch.
    do_reset("rst3");
    send_sync();
    for (int i = 0; i < 500; i++) cyc(1'b1, $urandom);
    do_reset("rst_mid");
    send_sync();
    for (int i = 0; i < WORDS; i++) cyc(1'b1, 32'(i) ^ 32'h5A5A_0000);
    cyc(1'b0, 32'h0);
    cyc(1'b1, 32'h0BAD_0BAD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
